// File: rtl/apb_cmd_master.sv
// Command-to-APB master: one valid/ready command becomes one APB transfer to FC, CONV or POOL.
// Latency: accept -> RSP_VALID is 3 cycles at zero wait states (1 cycle for a bad select).
// Backpressure: CMD_READY only in IDLE; response held until RSP_READY. APB_TIMEOUT_EN enables ACCESS abort.
module apb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [1:0]            CMD_SEL,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [31:0]           CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDATA,
    output logic [1:0]            RSP_ERR,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic                  PENABLE,
    output logic [2:0]            PSEL,
    input  logic [31:0]           PRDATA_FC,
    input  logic [31:0]           PRDATA_CONV,
    input  logic [31:0]           PRDATA_POOL,
    input  logic [2:0]            PREADY,
    input  logic [2:0]            PSLVERR
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state;
    logic [1:0]  sel_q;
    logic        sel_ready;
    logic        sel_err;
    logic [31:0] sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`endif

    // Only the selected slave's handshake bits and data are looked at.
    always_comb begin
        sel_ready = PREADY[2];
        sel_err   = PSLVERR[2];
        sel_rdata = PRDATA_POOL;
        case (sel_q)
            2'd0: begin
                sel_ready = PREADY[0];
                sel_err   = PSLVERR[0];
                sel_rdata = PRDATA_FC;
            end
            2'd1: begin
                sel_ready = PREADY[1];
                sel_err   = PSLVERR[1];
                sel_rdata = PRDATA_CONV;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            sel_q     <= 2'd0;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 2'b00;
            RSP_RDATA <= 32'd0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= 32'd0;
            PENABLE   <= 1'b0;
            PSEL      <= 3'b000;
`ifdef APB_TIMEOUT_EN
            tmo_cnt   <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // READY rises one cycle into IDLE, so the return cycle never accepts.
                    if (CMD_READY && CMD_VALID) begin
                        CMD_READY <= 1'b0;
                        if (CMD_SEL == 2'd3) begin
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 2'b11;
                            RSP_RDATA <= 32'd0;
                        end else begin
                            state  <= SETUP;
                            sel_q  <= CMD_SEL;
                            PADDR  <= CMD_ADDR;
                            PWRITE <= CMD_WRITE;
                            PWDATA <= CMD_WDATA;
                            PSEL   <= 3'b001 << CMD_SEL;
`ifdef APB_TIMEOUT_EN
                            tmo_cnt <= 16'd0;
`endif
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        PSEL      <= 3'b000;
                        PENABLE   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= sel_err ? 2'b01 : 2'b00;
                        RSP_RDATA <= (!PWRITE && !sel_err) ? sel_rdata : 32'd0;
                        state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        PSEL      <= 3'b000;
                        PENABLE   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 2'b10;
                        RSP_RDATA <= 32'd0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
